// File: rtl/uart_tx_if.sv
// Byte handshake between the producing core logic and the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, 8N1/8N2 frame out on tx.
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       tx_busy
);

  localparam int   BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
  localparam int   BAUD_W     = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic STOP_LAST  = (STOP_BITS == 2);

  if (BIT_CYCLES < 2) begin : g_bad_rate
    $error("uart_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q;
  logic                stop_q;
  logic                tx_q;
  logic                busy_q;
  logic [7:0]          shift_q;
  logic                baud_tc;
  logic                accept;
`ifdef UART_TX_PARITY_EN
  logic                parity_q;
`endif

  assign baud_tc      = (baud_q == BAUD_W'(BIT_CYCLES - 1));
  assign accept       = bus.tx_valid && (state_q == S_IDLE);
  assign bus.tx_ready = (state_q == S_IDLE);
  assign tx           = tx_q;
  assign tx_busy      = busy_q;

  // Baud counter idles at zero and wraps at the end of every bit period.
  always_comb begin
    baud_d = baud_q + BAUD_W'(1);
    if (state_q == S_IDLE || baud_tc) baud_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      baud_q <= baud_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (baud_tc) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (baud_tc) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
              stop_q  <= 1'b0;
`endif
            end else begin
              tx_q  <= shift_q[0];
              bit_q <= bit_q + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tc) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
        end
`endif
        S_STOP: begin
          if (baud_tc) begin
            if (stop_q == STOP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Shift register holds the not-yet-sent bits; bit 0 is loaded onto tx at each data bit start.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
      parity_q <= (^bus.tx_data) ^ (PARITY_ODD != 0);
`endif
    end else if (baud_tc && (state_q == S_START || (state_q == S_DATA && bit_q != 3'd7))) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (1 stop bit / even parity, 2 stop bits / odd parity).
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int BITC   = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if if_a();
  uart_tx_if if_b();
  logic tx_a, busy_a, tx_b, busy_b;

  uart_tx #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .tx(tx_a), .tx_busy(busy_a));
  uart_tx #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .tx(tx_b), .tx_busy(busy_b));

  int checks   = 0;
  int failures = 0;
  bit sel      = 1'b0;

  logic mon_tx, mon_busy, mon_rdy;
  assign mon_tx   = sel ? tx_b : tx_a;
  assign mon_busy = sel ? busy_b : busy_a;
  assign mon_rdy  = sel ? if_b.tx_ready : if_a.tx_ready;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel) begin
      if_b.tx_valid = v;
      if_b.tx_data  = d;
    end else begin
      if_a.tx_valid = v;
      if_a.tx_data  = d;
    end
  endtask

  // Expected line level during bit slot j of a frame carrying d.
  function automatic logic exp_bit(input int j, input logic [7:0] d, input bit odd);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (P == 1 && j == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // Sends d on the selected instance and checks every clock of the frame.
  task automatic run_frame(input logic [7:0] d, input bit noisy, input bit hold,
                           input logic [7:0] d_next, input string tag);
    int   n;
    int   errs;
    logic first;
    logic e;
    n = 1 + 8 + P + (sel ? 2 : 1);
    check({tag, "_ready_before"}, 32'(mon_rdy), 32'd1);
    drive(1'b1, d);
    tick();
    check({tag, "_busy_at_accept"}, 32'(mon_busy), 32'd1);
    if (hold) drive(1'b1, d_next);
    else      drive(1'b0, d);
    for (int j = 0; j < n; j++) begin
      e     = exp_bit(j, d, sel);
      first = mon_tx;
      errs  = 0;
      for (int c = 0; c < BITC; c++) begin
        if (mon_tx !== e) errs++;
        if (mon_busy !== 1'b1 || mon_rdy !== 1'b0) errs++;
        if (noisy) drive((c % 2) == 1, 8'($urandom));
        tick();
      end
      check($sformatf("%s_bit%0d", tag, j), 32'(first), 32'(e));
      check($sformatf("%s_bit%0d_hold", tag, j), 32'(errs), 32'd0);
    end
    if (!hold) drive(1'b0, d);
    check({tag, "_busy_end"}, 32'(mon_busy), 32'd0);
    check({tag, "_ready_end"}, 32'(mon_rdy), 32'd1);
    check({tag, "_tx_end"}, 32'(mon_tx), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    if_a.tx_valid = 1'b1; if_a.tx_data = 8'h55;
    if_b.tx_valid = 1'b1; if_b.tx_data = 8'hAA;
    repeat (3) tick();
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ready_a", 32'(if_a.tx_ready), 32'd1);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    if_a.tx_valid = 1'b0;
    if_b.tx_valid = 1'b0;
    tick();
    check("idle_tx_a", 32'(tx_a), 32'd1);

    sel = 1'b0;
    run_frame(8'hA5, 1'b0, 1'b0, 8'h00, "basic");
    run_frame(8'h00, 1'b0, 1'b1, 8'hFF, "b2b0");
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, "b2b1");

    run_frame(8'h96, 1'b1, 1'b0, 8'h00, "stable");
    repeat (30) tick();
    check("stable_no_extra_busy", 32'(busy_a), 32'd0);
    check("stable_no_extra_tx", 32'(tx_a), 32'd1);

    drive(1'b1, 8'h5A);
    tick();
    drive(1'b0, 8'h5A);
    repeat (45) tick();
    check("mid_busy", 32'(busy_a), 32'd1);
    check("mid_tx_bit3", 32'(tx_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", 32'(tx_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ready", 32'(if_a.tx_ready), 32'd1);
    run_frame(8'hC3, 1'b0, 1'b0, 8'h00, "after_rst");

    sel = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b1, 8'h81, "stop2_0");
    run_frame(8'h81, 1'b0, 1'b0, 8'h00, "stop2_1");

`ifdef UART_TX_PARITY_EN
    sel = 1'b0;
    run_frame(8'h07, 1'b0, 1'b0, 8'h00, "par_even");
    sel = 1'b1;
    run_frame(8'h07, 1'b0, 1'b0, 8'h00, "par_odd");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
